// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the pins, validates 11-bit frames, strips F0/E0 prefixes, reports make codes.
// Optional macro PS2_PARITY_CHECK_EN enables the odd-parity check; without it, only the start and stop bits are checked.
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] Ps2DataOut,
    output logic       Done,
    output logic       FrameErr
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Sync flops reset to 1 (idle bus) so that no false edge follows reset.
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          fall;
    logic          bit_dat;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          break_q, break_d;
    logic          ext_q, ext_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic          parity_q, parity_d;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign bit_dat = dat_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = bit_dat & (^shift_q ^ parity_q);
`else
    assign frame_ok = bit_dat;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        break_d   = break_q;
        ext_d     = ext_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d  = parity_q;
`endif
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (fall) begin
                if (!bit_dat) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (fall) begin
            cnt_d = '0;
            case (state_q)
                S_DATA: begin
                    shift_d   = {bit_dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = bit_dat;
`endif
                    state_d  = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        err_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        break_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (break_q) begin
                        // Key release: swallow the code and clear both prefixes.
                        break_d = 1'b0;
                        ext_d   = 1'b0;
                    end else begin
                        data_d = shift_q;
                        done_d = 1'b1;
                        ext_d  = 1'b0;
                    end
                end
            endcase
        end else if (cnt_q == TO_LAST) begin
            // Stalled partial frame; prefix flags survive the abandon.
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            cnt_q     <= '0;
            break_q   <= 1'b0;
            ext_q     <= 1'b0;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            break_q   <= break_d;
            ext_q     <= ext_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign Ps2DataOut = data_q;
    assign Done       = done_q;
    assign FrameErr   = err_q;

endmodule
